fsm_seq_ctrl: RTL and testbench
===============================

Name: fsm_seq_ctrl

Overview:
Front-end controller for the serial sequence-detector FSM. It arbitrates round-robin between two requesters, each submitting a WIDTH-bit word. It resets the detector, then shifts the granted word MSB-first onto the detector's serial input (one bit per clock) and counts the Moore-output detection pulses. It returns the count together with the requester ID over a valid/ready result port.

Parameters:
WIDTH, 8, bits per submitted word (number of SHIFT cycles); must be at least 2
CNT_W, 4, width of the detection counter and result count; saturating

Ports:
clock  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  WIDTH  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  WIDTH  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
fsm_w  out  1  serial bit to detector input w
fsm_rst  out  1  detector reset, active-low
det_in  in  1  detector Moore count output
res_valid  out  1  result available
res_id  out  1  requester that owns the result
res_count  out  CNT_W  detections counted for the word
res_ready  in  1  result consumer accepts
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, last_grant=1 (so req0 wins first), fsm_w=0, fsm_rst=0, res_valid=0, res_id=0, res_count=0, bit index=0, shift register=0.
- rst release: fsm_rst=1 from the first clock edge after release.
- States:
  - IDLE: reqN_ready = grantee's valid; combinational, IDLE only.
  - Grant: if only one valid, that requester wins. If both are valid, the requester other than last_grant wins.
  - Handshake edge: latch data and id, update last_grant, clear counter, go to CLEAR.
- CLEAR: one cycle with fsm_rst=0 and fsm_w=0, then go to SHIFT with index=0.
- SHIFT: WIDTH cycles; cycle k drives fsm_w = word[WIDTH-1-k]. After index WIDTH-1, go to DRAIN.
- DRAIN: one cycle with fsm_w=0, then go to RESULT.
- Counting:
  - Sample det_in and increment the counter when det_in=1, during SHIFT cycles k=1..WIDTH-1 and during DRAIN.
  - This gives exactly WIDTH samples, each observing the detector state after bit k-1.
  - det_in is ignored in IDLE, CLEAR, SHIFT k=0 and RESULT.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- RESULT:
  - res_valid=1; res_id and res_count are registered and held stable while res_ready=0.
  - On res_valid & res_ready: res_valid=0 on the next cycle and return to IDLE.
  - res_id and res_count keep their last value after the handshake.
- Latency, handshake at edge E0:
  - CLEAR occupies cycle E0..E1.
  - SHIFT occupies E1..E(WIDTH+1).
  - DRAIN occupies E(WIDTH+1)..E(WIDTH+2).
  - res_valid rises after E(WIDTH+2), i.e. WIDTH+2 edges after acceptance (10 for WIDTH=8).
- Throughput: next acceptance is no earlier than the edge after the result handshake, because ready is only asserted in IDLE.
- Request behaviour while busy: reqN_ready=0 and requests wait. Requesters must hold valid and data stable until ready.
- Reset mid-operation: returns to reset values immediately.
  - The in-flight word is discarded and no result is produced.
  - fsm_rst is asserted low, so the detector is reset too.
- fsm_w and fsm_rst are registered outputs (glitch-free).

Decomposition:
- Shared package fsm_ctrl_pkg holds:
  - state encoding constants: IDLE, CLEAR, SHIFT, DRAIN, RESULT as a 3-bit localparam set;
  - defaults for WIDTH and CNT_W;
  - requester ID constants REQ0=0 and REQ1=1.
- One natural sub-module, rr_arb2: two-requester round-robin arbiter.
  - Inputs: valid pair, last_grant, enable.
  - Outputs: grant one-hot and grant id.
  - Purely combinational; last_grant is stored in the parent.

Test Plan:
- The bench models the detector as a Moore "three consecutive 1s" detector: det_in is high in the cycle after the third consecutive 1, and the detector is cleared by fsm_rst=0.
- Reset and idle: hold rst=0 for 2 cycles, then release with no requests -> all outputs 0 during reset, fsm_rst=1 after the first edge, busy=0, req0/1_ready=0.
- Single word: req0 with 8'hFF, res_ready=1 -> fsm_w shows 1 for 8 cycles after the CLEAR cycle, then res_valid with res_id=0 and res_count=6, exactly 10 edges after acceptance.
- Pattern with reset between words:
  - req1 with 8'b1110_0111 -> res_id=1, res_count=2.
  - Then req1 with 8'h00 -> res_count=0, with no carry-over of detector state.
- Arbitration: req0 and req1 both held valid from reset -> grants go 0,1,0,1 over four words; the grantee's ready pulses for exactly one cycle each.
- Backpressure: res_ready=0 for 5 cycles in RESULT -> res_valid, res_id and res_count stay stable, both readys stay 0, and busy=1; acceptance resumes the cycle after res_ready=1.
- Reset mid-SHIFT: pull rst low at SHIFT k=4 -> all outputs return to reset values asynchronously and no result appears. After release, req0 (last_grant=1) wins and its word completes normally.

Source files
------------

// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared definitions for the sequence-detector front-end controller.
//   state_t   : controller state encoding
//   DEF_*     : default parameter values for the top level
//   REQ0/REQ1 : requester identifiers carried on res_id
package fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/fsm_seq_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
//   valid      : request pair, bit N for requester N
//   last_grant : id of the previous winner (stored by the parent)
//   enable     : when low no grant is issued
//   grant      : one-hot grant
//   grant_id   : id of the winner (meaningful when grant != 0)
module rr_arb2
  import fsm_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = REQ0;
    if (valid[0] && valid[1]) begin
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = REQ1;
    end

    grant = '0;
    if (enable && (valid != 2'b00)) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Front-end controller for a serial sequence-detector FSM.
// Arbitrates between two requesters, resets the detector, shifts the granted
// word MSB-first onto fsm_w and counts detector pulses on det_in, then
// returns the count and requester id over a valid/ready result port.
//   clock, rst            : clock (rising edge), async active-low reset
//   reqN_valid/data/ready : requester N word handshake (ready only in IDLE)
//   fsm_w, fsm_rst        : registered serial bit and active-low reset to detector
//   det_in                : detector Moore output
//   res_valid/id/count    : result handshake, res_ready from consumer
//   busy                  : high whenever not IDLE
module fsm_seq_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             fsm_w,
  output logic             fsm_rst,
  input  logic             det_in,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_d;
  logic             last_grant, last_grant_d;
  logic             own_id, own_id_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_sat;
  logic             res_id_d;
  logic [CNT_W-1:0] res_count_d;
  logic             fsm_w_d, fsm_rst_d;

  logic [1:0] grant;
  logic       grant_id;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = (state != IDLE);
  assign res_valid  = (state == RESULT);

  // Saturating increment of the detection counter for the current sample.
  always_comb begin
    cnt_sat = cnt;
    if (det_in && (cnt != '1)) begin
      cnt_sat = cnt + CNT_W'(1);
    end
  end

  // fsm_w is registered, so the bit for the next cycle is chosen here: the
  // CLEAR cycle preloads the MSB, and each SHIFT cycle presents the following
  // bit from the left-shifting register.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    own_id_d     = own_id;
    sh_d         = sh;
    idx_d        = idx;
    cnt_d        = cnt;
    res_id_d     = res_id;
    res_count_d  = res_count;
    fsm_w_d      = 1'b0;

    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d      = CLEAR;
          sh_d         = grant_id ? req1_data : req0_data;
          own_id_d     = grant_id;
          last_grant_d = grant_id;
          cnt_d        = '0;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        idx_d   = '0;
        fsm_w_d = sh[WIDTH-1];
        sh_d    = {sh[WIDTH-2:0], 1'b0};
      end
      SHIFT: begin
        // The k=0 sample would see the detector before any bit of this word.
        if (idx != '0) begin
          cnt_d = cnt_sat;
        end
        if (idx == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx + IDX_W'(1);
          fsm_w_d = sh[WIDTH-1];
          sh_d    = {sh[WIDTH-2:0], 1'b0};
        end
      end
      DRAIN: begin
        cnt_d       = cnt_sat;
        res_count_d = cnt_sat;
        res_id_d    = own_id;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fsm_rst_d = (state_d != CLEAR);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ1;
      own_id     <= REQ0;
      sh         <= '0;
      idx        <= '0;
      cnt        <= '0;
      res_id     <= REQ0;
      res_count  <= '0;
      fsm_w      <= 1'b0;
      fsm_rst    <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      own_id     <= own_id_d;
      sh         <= sh_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      res_id     <= res_id_d;
      res_count  <= res_count_d;
      fsm_w      <= fsm_w_d;
      fsm_rst    <= fsm_rst_d;
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed self-checking bench for fsm_seq_ctrl with a behavioural
// "three consecutive 1s" Moore detector attached to fsm_w/fsm_rst/det_in.
module tb_fsm_seq_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       fsm_w, fsm_rst, det_in;
  logic       res_valid, res_id, res_ready = 1'b1, busy;
  logic [3:0] res_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fsm_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clock(clock), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fsm_w(fsm_w), .fsm_rst(fsm_rst), .det_in(det_in),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .res_ready(res_ready), .busy(busy)
  );

  // Detector: high in the cycle after the third consecutive 1.
  logic [1:0] dst = 2'd0;
  always @(posedge clock) begin
    if (!fsm_rst)    dst <= 2'd0;
    else if (fsm_w)  dst <= (dst == 2'd3) ? 2'd3 : dst + 2'd1;
    else             dst <= 2'd0;
  end
  assign det_in = (dst == 2'd3);

  // Present a word on requester id and wait (bounded) for its handshake.
  task automatic submit(input bit id, input logic [7:0] d, output bit got);
    got = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        @(posedge clock); #1;
        got = 1'b1;
      end else begin
        @(posedge clock);
      end
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Count edges from just after acceptance until res_valid is seen.
  task automatic wait_result(output int edges);
    edges = -1;
    for (int n = 1; n <= 40 && edges < 0; n++) begin
      @(posedge clock); #1;
      if (res_valid) edges = n;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({fsm_w, fsm_rst, res_valid, res_id, res_count, busy, req0_ready, req1_ready} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all 0",
               {fsm_w, fsm_rst, res_valid, res_id, res_count, busy, req0_ready, req1_ready});
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (fsm_rst !== 1'b0) begin
      failures++; $display("FAIL reset_hold_fsm_rst: got %b expected 0", fsm_rst);
    end
    rst = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({fsm_rst, busy, req0_ready, req1_ready, res_valid} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_release: got %b expected 10000", {fsm_rst, busy, req0_ready, req1_ready, res_valid});
    end
  endtask

  task automatic test_single();
    bit got;
    logic [7:0] d;
    d = 8'hFF;
    res_ready = 1'b1;
    submit(1'b0, d, got);
    checks++;
    if (!got) begin failures++; $display("FAIL single_accept: got no ready expected ready"); end
    checks++;
    if ({fsm_w, fsm_rst, busy} !== 3'b001) begin
      failures++; $display("FAIL single_clear: got %b expected 001", {fsm_w, fsm_rst, busy});
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      checks++;
      if ({fsm_w, fsm_rst} !== {d[7-k], 1'b1}) begin
        failures++; $display("FAIL single_shift%0d: got %b expected %b", k, {fsm_w, fsm_rst}, {d[7-k], 1'b1});
      end
    end
    @(posedge clock); #1;
    checks++;
    if ({fsm_w, res_valid} !== 2'b00) begin
      failures++; $display("FAIL single_drain: got %b expected 00", {fsm_w, res_valid});
    end
    @(posedge clock); #1;
    checks++;
    if ({res_valid, res_id, res_count} !== {1'b1, 1'b0, 4'd6}) begin
      failures++; $display("FAIL single_result: got v=%b id=%b cnt=%0d expected v=1 id=0 cnt=6",
                           res_valid, res_id, res_count);
    end
    @(posedge clock); #1;
    checks++;
    if ({res_valid, busy, res_count} !== {1'b0, 1'b0, 4'd6}) begin
      failures++; $display("FAIL single_after: got v=%b busy=%b cnt=%0d expected v=0 busy=0 cnt=6",
                           res_valid, busy, res_count);
    end
  endtask

  task automatic test_pattern();
    bit got;
    int e;
    logic [7:0] words [2];
    logic [3:0] exp_cnt [2];
    words[0] = 8'b1110_0111; exp_cnt[0] = 4'd2;
    words[1] = 8'h00;        exp_cnt[1] = 4'd0;
    for (int w = 0; w < 2; w++) begin
      submit(1'b1, words[w], got);
      wait_result(e);
      checks++;
      if (!got || e != 10) begin
        failures++; $display("FAIL pattern%0d_latency: got accept=%0d edges=%0d expected 1/10", w, got, e);
      end
      checks++;
      if ({res_id, res_count} !== {1'b1, exp_cnt[w]}) begin
        failures++; $display("FAIL pattern%0d_result: got id=%b cnt=%0d expected id=1 cnt=%0d",
                             w, res_id, res_count, exp_cnt[w]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_arbitration();
    int e;
    bit seen;
    logic [3:0] exp_cnt;
    do_reset();
    req0_data = 8'hA5; req1_data = 8'h3C;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        #1;
        if (req0_ready || req1_ready) seen = 1'b1;
        else @(posedge clock);
      end
      checks++;
      if ({req1_ready, req0_ready} !== ((w % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL arb%0d_grant: got %b expected %b", w, {req1_ready, req0_ready},
                             (w % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clock); #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        failures++; $display("FAIL arb%0d_pulse: got %b expected 00", w, {req1_ready, req0_ready});
      end
      wait_result(e);
      exp_cnt = (w % 2 == 0) ? 4'd0 : 4'd2;
      checks++;
      if (e != 10 || res_id !== w[0] || res_count !== exp_cnt) begin
        failures++; $display("FAIL arb%0d_result: got edges=%0d id=%b cnt=%0d expected 10/%b/%0d",
                             w, e, res_id, res_count, w[0], exp_cnt);
      end
      @(posedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    bit got;
    int e;
    res_ready = 1'b0;
    submit(1'b0, 8'hFF, got);
    wait_result(e);
    checks++;
    if (!got || e != 10) begin
      failures++; $display("FAIL bp_latency: got accept=%0d edges=%0d expected 1/10", got, e);
    end
    req1_data = 8'h07; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({res_valid, res_id, res_count, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL bp_hold%0d: got v=%b id=%b cnt=%0d r0=%b r1=%b busy=%b expected 1/0/6/0/0/1",
                             i, res_valid, res_id, res_count, req0_ready, req1_ready, busy);
      end
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({res_valid, req1_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL bp_resume: got v=%b r1=%b busy=%b expected 0/1/0", res_valid, req1_ready, busy);
    end
    @(posedge clock); #1;
    req1_valid = 1'b0;
    wait_result(e);
    checks++;
    if (e != 10 || {res_id, res_count} !== {1'b1, 4'd1}) begin
      failures++; $display("FAIL bp_next: got edges=%0d id=%b cnt=%0d expected 10/1/1", e, res_id, res_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    bit got;
    int e;
    res_ready = 1'b1;
    submit(1'b0, 8'hFF, got);
    repeat (5) begin @(posedge clock); #1; end
    checks++;
    if (fsm_w !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre: got w=%b busy=%b expected 1/1", fsm_w, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({fsm_w, fsm_rst, res_valid, res_id, res_count, busy} !== 9'b0) begin
      failures++; $display("FAIL mid_async: got %b expected all 0",
                           {fsm_w, fsm_rst, res_valid, res_id, res_count, busy});
    end
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;
    e = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (res_valid || busy) e++;
    end
    checks++;
    if (e != 0) begin
      failures++; $display("FAIL mid_no_result: got %0d active cycles expected 0", e);
    end
    req1_data = 8'h55; req1_valid = 1'b1;
    submit(1'b0, 8'b0111_0000, got);
    req1_valid = 1'b0;
    checks++;
    if (!got) begin failures++; $display("FAIL mid_regrant: got no req0 grant expected req0 grant"); end
    wait_result(e);
    checks++;
    if (e != 10 || {res_id, res_count} !== {1'b0, 4'd1}) begin
      failures++; $display("FAIL mid_after: got edges=%0d id=%b cnt=%0d expected 10/0/1", e, res_id, res_count);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
